reservation_station: RTL and testbench

//  Holds ALU-class instructions sent by the dispatcher until both source operands are valid,

---
 rtl/reservation_station.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_reservation_station.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// ---------------------------------------------------------------------------
// reservation_station
//   Buffers ALU-class instructions from the dispatcher until both source
//   operands are valid, then issues one ready entry per cycle to the ALU.
//   Operands are woken by snooping the ALU and LSB common data buses; a ROB
//   clear flushes every entry.
//
//   Optional feature macro: RS_OLDEST_FIRST_EN
//     defined   : each entry keeps a saturating AGE_W age counter and issue
//                 picks the oldest ready entry (ties -> lowest index)
//     undefined : no age state, issue picks the lowest-index ready entry
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   new_inst_in, inst_in,    dispatch request and instruction fields
//   imm_in, pc_in, dest_in,
//   vj_in, vk_in, qj_in,
//   qk_in
//   alu_cdb_*, lsb_cdb_*     result broadcasts used for operand wake-up
//   rob_clear_in             flush all entries
//   full_out                 combinational, all entries busy
//   alu_*_out                registered issue port to the ALU
//
// Handshake: the dispatcher may only assert new_inst_in while full_out is
//   low; a request while full is dropped. The ALU side has no back-pressure:
//   alu_valid_out is high for exactly the cycle an instruction is presented.
// ---------------------------------------------------------------------------
module reservation_station #(
    parameter int RS_SIZE = 8,
    parameter int TAG_W   = 4,
    parameter int INST_W  = 6,
    parameter int AGE_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              new_inst_in,
    input  logic [INST_W-1:0] inst_in,
    input  logic [31:0]       imm_in,
    input  logic [31:0]       pc_in,
    input  logic [TAG_W-1:0]  dest_in,
    input  logic [31:0]       vj_in,
    input  logic [31:0]       vk_in,
    input  logic [TAG_W-1:0]  qj_in,
    input  logic [TAG_W-1:0]  qk_in,
    input  logic              alu_cdb_valid,
    input  logic [TAG_W-1:0]  alu_cdb_tag,
    input  logic [31:0]       alu_cdb_val,
    input  logic              lsb_cdb_valid,
    input  logic [TAG_W-1:0]  lsb_cdb_tag,
    input  logic [31:0]       lsb_cdb_val,
    input  logic              rob_clear_in,
    output logic              full_out,
    output logic              alu_valid_out,
    output logic [INST_W-1:0] alu_inst_out,
    output logic [31:0]       alu_v1_out,
    output logic [31:0]       alu_v2_out,
    output logic [31:0]       alu_imm_out,
    output logic [31:0]       alu_pc_out,
    output logic [TAG_W-1:0]  alu_dest_out
);
    localparam int IDX_W = $clog2(RS_SIZE);

    // Entry storage
    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [INST_W-1:0]  inst_q [RS_SIZE];
    logic [INST_W-1:0]  inst_d [RS_SIZE];
    logic [31:0]        vj_q   [RS_SIZE];
    logic [31:0]        vj_d   [RS_SIZE];
    logic [31:0]        vk_q   [RS_SIZE];
    logic [31:0]        vk_d   [RS_SIZE];
    logic [TAG_W-1:0]   qj_q   [RS_SIZE];
    logic [TAG_W-1:0]   qj_d   [RS_SIZE];
    logic [TAG_W-1:0]   qk_q   [RS_SIZE];
    logic [TAG_W-1:0]   qk_d   [RS_SIZE];
    logic [31:0]        imm_q  [RS_SIZE];
    logic [31:0]        imm_d  [RS_SIZE];
    logic [31:0]        pc_q   [RS_SIZE];
    logic [31:0]        pc_d   [RS_SIZE];
    logic [TAG_W-1:0]   dest_q [RS_SIZE];
    logic [TAG_W-1:0]   dest_d [RS_SIZE];
`ifdef RS_OLDEST_FIRST_EN
    logic [AGE_W-1:0]   age_q  [RS_SIZE];
    logic [AGE_W-1:0]   age_d  [RS_SIZE];
    logic [AGE_W-1:0]   best_age;
`endif

    // Issue register
    logic              alu_valid_q, alu_valid_d;
    logic [INST_W-1:0] alu_inst_q, alu_inst_d;
    logic [31:0]       alu_v1_q, alu_v1_d, alu_v2_q, alu_v2_d;
    logic [31:0]       alu_imm_q, alu_imm_d, alu_pc_q, alu_pc_d;
    logic [TAG_W-1:0]  alu_dest_q, alu_dest_d;

    logic [RS_SIZE-1:0] ready;
    logic               issue_valid, free_valid;
    logic [IDX_W-1:0]   issue_idx, free_idx;

    // A CDB hit needs a live broadcast and a real dependency: tag 0 means
    // "already valid" and must never be overwritten by a broadcast.
    function automatic logic cdb_hit(input logic v, input logic [TAG_W-1:0] cdb_tag,
                                     input logic [TAG_W-1:0] q);
        return v && (q != '0) && (q == cdb_tag);
    endfunction

    assign full_out = &busy_q;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
        end
    end

    // Lowest-index free entry; scanning downward lets the lowest index win.
    always_comb begin
        free_valid = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_valid = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Issue selection on pre-edge state.
    always_comb begin
        issue_valid = 1'b0;
        issue_idx   = '0;
`ifdef RS_OLDEST_FIRST_EN
        best_age = '0;
        // Strictly-greater compare keeps the lowest index on equal ages.
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && (!issue_valid || age_q[i] > best_age)) begin
                issue_valid = 1'b1;
                issue_idx   = IDX_W'(i);
                best_age    = age_q[i];
            end
        end
`else
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issue_valid = 1'b1;
                issue_idx   = IDX_W'(i);
            end
        end
`endif
    end

    // Entry next-state: wake-up, issue release, dispatch, flush (last wins).
    always_comb begin
        busy_d = busy_q;
        inst_d = inst_q;
        vj_d   = vj_q;
        vk_d   = vk_q;
        qj_d   = qj_q;
        qk_d   = qk_q;
        imm_d  = imm_q;
        pc_d   = pc_q;
        dest_d = dest_q;
`ifdef RS_OLDEST_FIRST_EN
        age_d  = age_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && (age_q[i] != '1)) age_d[i] = age_q[i] + 1'b1;
        end
`endif
        for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i]) begin
                if (cdb_hit(alu_cdb_valid, alu_cdb_tag, qj_q[i])) begin
                    vj_d[i] = alu_cdb_val;
                    qj_d[i] = '0;
                end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_tag, qj_q[i])) begin
                    vj_d[i] = lsb_cdb_val;
                    qj_d[i] = '0;
                end
                if (cdb_hit(alu_cdb_valid, alu_cdb_tag, qk_q[i])) begin
                    vk_d[i] = alu_cdb_val;
                    qk_d[i] = '0;
                end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_tag, qk_q[i])) begin
                    vk_d[i] = lsb_cdb_val;
                    qk_d[i] = '0;
                end
            end
        end
        if (issue_valid) busy_d[issue_idx] = 1'b0;
        // The free slot is never the issuing slot, so dispatch cannot collide.
        if (new_inst_in && free_valid) begin
            busy_d[free_idx] = 1'b1;
            inst_d[free_idx] = inst_in;
            imm_d[free_idx]  = imm_in;
            pc_d[free_idx]   = pc_in;
            dest_d[free_idx] = dest_in;
            vj_d[free_idx]   = vj_in;
            qj_d[free_idx]   = qj_in;
            vk_d[free_idx]   = vk_in;
            qk_d[free_idx]   = qk_in;
`ifdef RS_OLDEST_FIRST_EN
            age_d[free_idx]  = '0;
`endif
            // Same-cycle forwarding: a producer broadcasting now would
            // otherwise be missed forever.
            if (cdb_hit(alu_cdb_valid, alu_cdb_tag, qj_in)) begin
                vj_d[free_idx] = alu_cdb_val;
                qj_d[free_idx] = '0;
            end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_tag, qj_in)) begin
                vj_d[free_idx] = lsb_cdb_val;
                qj_d[free_idx] = '0;
            end
            if (cdb_hit(alu_cdb_valid, alu_cdb_tag, qk_in)) begin
                vk_d[free_idx] = alu_cdb_val;
                qk_d[free_idx] = '0;
            end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_tag, qk_in)) begin
                vk_d[free_idx] = lsb_cdb_val;
                qk_d[free_idx] = '0;
            end
        end
        if (rob_clear_in) busy_d = '0;
    end

    // Issue register next-state; payload holds when nothing issues.
    always_comb begin
        alu_valid_d = 1'b0;
        alu_inst_d  = alu_inst_q;
        alu_v1_d    = alu_v1_q;
        alu_v2_d    = alu_v2_q;
        alu_imm_d   = alu_imm_q;
        alu_pc_d    = alu_pc_q;
        alu_dest_d  = alu_dest_q;
        if (issue_valid && !rob_clear_in) begin
            alu_valid_d = 1'b1;
            alu_inst_d  = inst_q[issue_idx];
            alu_v1_d    = vj_q[issue_idx];
            alu_v2_d    = vk_q[issue_idx];
            alu_imm_d   = imm_q[issue_idx];
            alu_pc_d    = pc_q[issue_idx];
            alu_dest_d  = dest_q[issue_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            alu_valid_q <= 1'b0;
            alu_inst_q  <= '0;
            alu_v1_q    <= '0;
            alu_v2_q    <= '0;
            alu_imm_q   <= '0;
            alu_pc_q    <= '0;
            alu_dest_q  <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                inst_q[i] <= '0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
                qj_q[i]   <= '0;
                qk_q[i]   <= '0;
                imm_q[i]  <= '0;
                pc_q[i]   <= '0;
                dest_q[i] <= '0;
`ifdef RS_OLDEST_FIRST_EN
                age_q[i]  <= '0;
`endif
            end
        end else begin
            busy_q      <= busy_d;
            inst_q      <= inst_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            dest_q      <= dest_d;
`ifdef RS_OLDEST_FIRST_EN
            age_q       <= age_d;
`endif
            alu_valid_q <= alu_valid_d;
            alu_inst_q  <= alu_inst_d;
            alu_v1_q    <= alu_v1_d;
            alu_v2_q    <= alu_v2_d;
            alu_imm_q   <= alu_imm_d;
            alu_pc_q    <= alu_pc_d;
            alu_dest_q  <= alu_dest_d;
        end
    end

    assign alu_valid_out = alu_valid_q;
    assign alu_inst_out  = alu_inst_q;
    assign alu_v1_out    = alu_v1_q;
    assign alu_v2_out    = alu_v2_q;
    assign alu_imm_out   = alu_imm_q;
    assign alu_pc_out    = alu_pc_q;
    assign alu_dest_out  = alu_dest_q;

    // The dispatcher must stall on full_out; such a request is dropped.
    dispatch_while_full: assert property (@(posedge clk) disable iff (rst)
        !(new_inst_in && full_out))
        else $warning("reservation_station: dispatch request while full was dropped");

endmodule

// File: tb/tb_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_reservation_station
//   Directed bench for reservation_station. Expected issue records are
//   pushed to exp_q when the stimulus that should produce them is driven,
//   and popped when alu_valid_out is expected. Outputs are sampled 1 time
//   unit after the rising edge; inputs change at the same point.
// ---------------------------------------------------------------------------
module tb_reservation_station;
    localparam int TAG_W  = 4;
    localparam int INST_W = 6;
    localparam int W      = TAG_W + INST_W + 128;
    typedef logic [W-1:0] word_t;

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              new_inst_in;
    logic [INST_W-1:0] inst_in;
    logic [31:0]       imm_in, pc_in, vj_in, vk_in;
    logic [TAG_W-1:0]  dest_in, qj_in, qk_in;
    logic              alu_cdb_valid, lsb_cdb_valid;
    logic [TAG_W-1:0]  alu_cdb_tag, lsb_cdb_tag;
    logic [31:0]       alu_cdb_val, lsb_cdb_val;
    logic              rob_clear_in;
    logic              full_out, alu_valid_out;
    logic [INST_W-1:0] alu_inst_out;
    logic [31:0]       alu_v1_out, alu_v2_out, alu_imm_out, alu_pc_out;
    logic [TAG_W-1:0]  alu_dest_out;

    reservation_station dut (
        .clk(clk), .rst(rst),
        .new_inst_in(new_inst_in), .inst_in(inst_in), .imm_in(imm_in), .pc_in(pc_in),
        .dest_in(dest_in), .vj_in(vj_in), .vk_in(vk_in), .qj_in(qj_in), .qk_in(qk_in),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_val(lsb_cdb_val),
        .rob_clear_in(rob_clear_in), .full_out(full_out), .alu_valid_out(alu_valid_out),
        .alu_inst_out(alu_inst_out), .alu_v1_out(alu_v1_out), .alu_v2_out(alu_v2_out),
        .alu_imm_out(alu_imm_out), .alu_pc_out(alu_pc_out), .alu_dest_out(alu_dest_out)
    );

    // Scoreboard
    word_t exp_q[$];
    int    n_pass;
    int    n_total;

    function automatic word_t obs_word();
        return {alu_dest_out, alu_inst_out, alu_v1_out, alu_v2_out, alu_imm_out, alu_pc_out};
    endfunction

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic [TAG_W-1:0] dest, input logic [INST_W-1:0] inst,
                            input logic [31:0] v1, input logic [31:0] v2,
                            input logic [31:0] imm, input logic [31:0] pc);
        exp_q.push_back({dest, inst, v1, v2, imm, pc});
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, word_t'(alu_valid_out), word_t'(1'b0));
    endtask

    task automatic check_issue(input string tag);
        word_t e;
        check({tag, "_valid"}, word_t'(alu_valid_out), word_t'(1'b1));
        check({tag, "_sb_has_entry"}, word_t'(exp_q.size() != 0), word_t'(1'b1));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_payload"}, obs_word(), e);
        end
    endtask

    // Driver tasks
    task automatic clear_inputs();
        new_inst_in = 1'b0; inst_in = '0; imm_in = '0; pc_in = '0; dest_in = '0;
        vj_in = '0; vk_in = '0; qj_in = '0; qk_in = '0;
        alu_cdb_valid = 1'b0; alu_cdb_tag = '0; alu_cdb_val = '0;
        lsb_cdb_valid = 1'b0; lsb_cdb_tag = '0; lsb_cdb_val = '0;
        rob_clear_in = 1'b0;
    endtask

    task automatic drive_disp(input logic [INST_W-1:0] inst, input logic [31:0] vj,
                              input logic [31:0] vk, input logic [TAG_W-1:0] qj,
                              input logic [TAG_W-1:0] qk, input logic [TAG_W-1:0] dest,
                              input logic [31:0] imm, input logic [31:0] pc);
        new_inst_in = 1'b1; inst_in = inst; vj_in = vj; vk_in = vk;
        qj_in = qj; qk_in = qk; dest_in = dest; imm_in = imm; pc_in = pc;
    endtask

    task automatic drive_alu_cdb(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        alu_cdb_valid = 1'b1; alu_cdb_tag = tag; alu_cdb_val = val;
    endtask

    task automatic drive_lsb_cdb(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        lsb_cdb_valid = 1'b1; lsb_cdb_tag = tag; lsb_cdb_val = val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b, im, p;
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", word_t'(alu_valid_out), word_t'(1'b0));
        check("reset_full", word_t'(full_out), word_t'(1'b0));
        check("reset_payload", obs_word(), '0);
        rst = 1'b0;

        // Ready path
        drive_disp(6'd1, 32'd5, 32'd7, 4'd0, 4'd0, 4'd3, 32'h100, 32'h1000);
        push_exp(4'd3, 6'd1, 32'd5, 32'd7, 32'h100, 32'h1000);
        tick(); check_idle("ready_write_edge");
        tick(); check_issue("ready_issue");
        tick(); check_idle("ready_after");

        // Wake-up via ALU CDB
        b = $urandom; im = $urandom; p = $urandom;
        drive_disp(6'd2, 32'hdeadbeef, b, 4'd2, 4'd0, 4'd5, im, p);
        tick(); check_idle("wake_write");
        tick(); check_idle("wake_hold");
        drive_alu_cdb(4'd2, 32'h10);
        push_exp(4'd5, 6'd2, 32'h10, b, im, p);
        tick(); check_idle("wake_edge");
        tick(); check_issue("wake_issue");

        // Same-cycle forwarding from both CDBs
        drive_disp(6'd3, 32'd0, 32'd0, 4'd4, 4'd5, 4'd7, 32'h44, 32'h2000);
        drive_alu_cdb(4'd4, 32'd9);
        drive_lsb_cdb(4'd5, 32'd11);
        push_exp(4'd7, 6'd3, 32'd9, 32'd11, 32'h44, 32'h2000);
        tick(); check_idle("fwd_write");
        tick(); check_issue("fwd_issue");

        // Both CDBs wake both operands of one entry, crossed sources
        a = $urandom; b = $urandom;
        drive_disp(6'd4, 32'd0, 32'd0, 4'd7, 4'd8, 4'd9, 32'h55, 32'h3000);
        tick(); check_idle("dual_write");
        drive_alu_cdb(4'd8, b);
        drive_lsb_cdb(4'd7, a);
        push_exp(4'd9, 6'd4, a, b, 32'h55, 32'h3000);
        tick(); check_idle("dual_wake");
        tick(); check_issue("dual_issue");

        // Tag 0 never matches a broadcast
        drive_disp(6'd5, 32'h55, 32'h66, 4'd0, 4'd0, 4'd10, 32'h1, 32'h4000);
        drive_alu_cdb(4'd0, 32'hdead);
        drive_lsb_cdb(4'd0, 32'hbeef);
        push_exp(4'd10, 6'd5, 32'h55, 32'h66, 32'h1, 32'h4000);
        tick(); check_idle("tag0_write");
        tick(); check_issue("tag0_issue");
        tick(); check_idle("tag0_after");

        // Back-to-back ready dispatches pipeline one per cycle
        for (int k = 0; k < 4; k++) begin
            a = 32'($urandom_range(0, 1000)); b = $urandom; im = $urandom; p = $urandom;
            drive_disp(6'(k + 8), a, b, 4'd0, 4'd0, 4'(k + 1), im, p);
            push_exp(4'(k + 1), 6'(k + 8), a, b, im, p);
            tick();
            if (k == 0) check_idle("pipe_first");
            else check_issue("pipe_issue");
        end
        tick(); check_issue("pipe_last");
        tick(); check_idle("pipe_drained");

        // Fill, overflow ignored, flush
        for (int k = 0; k < 8; k++) begin
            drive_disp(6'd6, 32'(k), 32'(k), 4'd6, 4'd0, 4'(k + 1), 32'd0, 32'(k));
            tick();
            check("fill_full", word_t'(full_out), word_t'(k == 7));
        end
        drive_disp(6'd7, 32'd1, 32'd2, 4'd0, 4'd0, 4'd15, 32'd0, 32'h5000);
        check("overflow_full", word_t'(full_out), word_t'(1'b1));
        tick(); check_idle("overflow_write");
        check("overflow_still_full", word_t'(full_out), word_t'(1'b1));
        tick(); check_idle("overflow_ignored");
        rob_clear_in = 1'b1;
        tick();
        check("flush_full", word_t'(full_out), word_t'(1'b0));
        check_idle("flush_valid");
        drive_alu_cdb(4'd6, 32'h77);
        tick(); check_idle("flush_bcast");
        tick(); check_idle("flush_no_issue1");
        tick(); check_idle("flush_no_issue2");

        // Flush overrides a dispatch in the same cycle
        drive_disp(6'd1, 32'd1, 32'd1, 4'd0, 4'd0, 4'd1, 32'd0, 32'd0);
        rob_clear_in = 1'b1;
        tick(); check("flush_disp_full", word_t'(full_out), word_t'(1'b0));
        tick(); check_idle("flush_disp_none");

        // Flush overrides an issue in the same cycle
        drive_disp(6'd1, 32'd2, 32'd2, 4'd0, 4'd0, 4'd2, 32'd0, 32'd0);
        tick(); check_idle("flush_iss_write");
        rob_clear_in = 1'b1;
        tick(); check_idle("flush_iss_none");
        tick(); check_idle("flush_iss_after");

        // Ordering: entry 2 older than entry 0, both woken together
        drive_disp(6'd20, 32'd0, 32'h0a, 4'd10, 4'd0, 4'd1, 32'h20, 32'h6000);
        tick(); check_idle("ord_x0");
        drive_disp(6'd21, 32'd0, 32'h0b, 4'd12, 4'd0, 4'd2, 32'h21, 32'h6004);
        tick(); check_idle("ord_x1");
        drive_disp(6'd22, 32'd0, 32'h0c, 4'd11, 4'd0, 4'd3, 32'h22, 32'h6008);
        tick(); check_idle("ord_x2");
        drive_alu_cdb(4'd10, 32'h100);
        push_exp(4'd1, 6'd20, 32'h100, 32'h0a, 32'h20, 32'h6000);
        tick(); check_idle("ord_wake_x0");
        tick(); check_issue("ord_issue_x0");
        drive_disp(6'd23, 32'd0, 32'h0d, 4'd10, 4'd0, 4'd4, 32'h23, 32'h600c);
        tick(); check_idle("ord_y");
        drive_alu_cdb(4'd10, 32'h200);
        drive_lsb_cdb(4'd11, 32'h300);
`ifdef RS_OLDEST_FIRST_EN
        push_exp(4'd3, 6'd22, 32'h300, 32'h0c, 32'h22, 32'h6008);
        push_exp(4'd4, 6'd23, 32'h200, 32'h0d, 32'h23, 32'h600c);
`else
        push_exp(4'd4, 6'd23, 32'h200, 32'h0d, 32'h23, 32'h600c);
        push_exp(4'd3, 6'd22, 32'h300, 32'h0c, 32'h22, 32'h6008);
`endif
        tick(); check_idle("ord_wake_both");
        tick(); check_issue("ord_first");
        tick(); check_issue("ord_second");
        drive_alu_cdb(4'd12, 32'h400);
        push_exp(4'd2, 6'd21, 32'h400, 32'h0b, 32'h21, 32'h6004);
        tick(); check_idle("ord_wake_x1");
        tick(); check_issue("ord_issue_x1");

        // Asynchronous reset while full
        for (int k = 0; k < 8; k++) begin
            drive_disp(6'd9, 32'd0, 32'd0, 4'd13, 4'd0, 4'(k + 1), 32'd0, 32'd0);
            tick();
        end
        check("pre_reset_full", word_t'(full_out), word_t'(1'b1));
        #2 rst = 1'b1;
        #1;
        check("async_reset_full", word_t'(full_out), word_t'(1'b0));
        check("async_reset_valid", word_t'(alu_valid_out), word_t'(1'b0));
        @(posedge clk);
        #1 rst = 1'b0;
        drive_alu_cdb(4'd13, 32'h99);
        tick(); check_idle("post_reset_bcast");
        tick(); check_idle("post_reset_empty");

        // Reset while an issue is on the output
        a = $urandom; b = $urandom;
        drive_disp(6'd30, a, b, 4'd0, 4'd0, 4'd6, 32'h7, 32'h7000);
        push_exp(4'd6, 6'd30, a, b, 32'h7, 32'h7000);
        tick(); check_idle("rst2_write");
        tick(); check_issue("rst2_issue");
        #2 rst = 1'b1;
        #1;
        check("rst2_valid", word_t'(alu_valid_out), word_t'(1'b0));
        check("rst2_payload", obs_word(), '0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(); check_idle("rst2_after");

        check("sb_empty", word_t'(exp_q.size()), word_t'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
